dac_spi_ctrl: RTL

Serial-port configuration master for the N210 TX DAC, driving the `dac_sclk`/`dac_sen`/`dac_smosi`/`dac_smiso` pins from inside the platform top (`mkFTop_n210`).
- Converts single register write/read requests from the control plane into 16-bit DAC SPI frames.
- Returns one response per request.
- Provides the DAC setup path that precedes enabling the `dac_da`/`dac_db` sample buses.

---
 rtl/dac_spi_pkg.sv | 28 ++
 rtl/dac_spi_ctrl_tick.sv | 34 +++
 rtl/dac_spi_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dac_spi_pkg.sv
// Shared types, frame layout and frame builder for the DAC serial-port master.
package dac_spi_pkg;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 8;
    localparam int RNW_BIT = 15;
    localparam int LEN_HI  = 14;
    localparam int LEN_LO  = 13;
    localparam int ADDR_HI = 12;
    localparam int ADDR_LO = 8;
    localparam int ADDR_W  = ADDR_HI - ADDR_LO + 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

    // Single-byte frame: rnw, length 00, address, then write data (zero on reads).
    function automatic logic [FRAME_W-1:0] build_frame(input logic              rnw,
                                                       input logic [ADDR_W-1:0] addr,
                                                       input logic [DATA_W-1:0] wdata);
        logic [FRAME_W-1:0] f;
        f                  = '0;
        f[RNW_BIT]         = rnw;
        f[LEN_HI:LEN_LO]   = 2'b00;
        f[ADDR_HI:ADDR_LO] = addr;
        f[DATA_W-1:0]      = rnw ? '0 : wdata;
        return f;
    endfunction

endpackage

// File: rtl/dac_spi_ctrl_tick.sv
// SCLK half-period divider: counts 0..CLK_DIV-1 and pulses tick_o on the last count.
module dac_spi_tick
    import dac_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [7:0] TC = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i || (cnt_q == TC)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == TC);

endmodule

// File: rtl/dac_spi_ctrl.sv
// SPI mode-0 configuration master for the TX DAC: one 16-bit frame per request, one response each.
// Define DAC_SPI_READBACK_EN to enable register reads; otherwise every request is sent as a write.
//
// state | meaning
// IDLE  | ready for a request
// SETUP | sen low, bit 15 presented, one half-period
// SHIFT | 16 bit periods, low half then high half
// HOLD  | sen low, sclk low, one half-period
// GAP   | sen high, one half-period, response on the last cycle
module dac_spi_ctrl
    import dac_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rnw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              dac_sclk,
    output logic              dac_sen,
    output logic              dac_smosi,
    input  logic              dac_smiso_i
);

    generate
        if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("dac_spi_ctrl: CLK_DIV must be in 2..255");
        end
    endgenerate

    localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [3:0]         bit_q, bit_d;
    logic               phase_q, phase_d;
    logic               sclk_q, sclk_d;
    logic               sen_q, sen_d;
    logic               smosi_q, smosi_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               tick;
    logic               xfer;
    logic               rnw_eff;

    assign req_ready = (state_q == IDLE);
    assign xfer      = req_valid && req_ready;

    dac_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        bit_d       = bit_q;
        phase_d     = phase_q;
        sclk_d      = 1'b0;
        sen_d       = 1'b1;
        smosi_d     = 1'b0;
        rsp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    frame_d = build_frame(rnw_eff, req_addr, req_wdata);
                    bit_d   = '0;
                    phase_d = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                sen_d   = 1'b0;
                smosi_d = frame_q[RNW_BIT];
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                // Outputs are registered, so the bit index changes together with the falling edge.
                sen_d   = 1'b0;
                sclk_d  = phase_q;
                smosi_d = frame_q[LAST_BIT - bit_q];
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            bit_d   = '0;
                            state_d = HOLD;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end
            HOLD: begin
                sen_d = 1'b0;
                if (tick) state_d = GAP;
            end
            GAP: begin
                if (tick) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            bit_q       <= '0;
            phase_q     <= 1'b0;
            sclk_q      <= 1'b0;
            sen_q       <= 1'b1;
            smosi_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            bit_q       <= bit_d;
            phase_q     <= phase_d;
            sclk_q      <= sclk_d;
            sen_q       <= sen_d;
            smosi_q     <= smosi_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef DAC_SPI_READBACK_EN
    logic              rise_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    assign rnw_eff = req_rnw;

    // rise_q marks the first cycle sclk is high; only the last eight samples survive the shift.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rise_q      <= 1'b0;
            rx_q        <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rise_q <= sclk_d && !sclk_q;
            if (state_q == IDLE) begin
                rx_q <= '0;
            end else if (rise_q) begin
                rx_q <= {rx_q[DATA_W-2:0], dac_smiso_i};
            end
            if (state_q == GAP && tick) begin
                rsp_rdata_q <= frame_q[RNW_BIT] ? rx_q : '0;
            end
        end
    end

    assign rsp_rdata = rsp_rdata_q;
`else
    logic unused_readback;

    assign rnw_eff         = 1'b0;
    assign unused_readback = req_rnw ^ dac_smiso_i;
    assign rsp_rdata       = '0;
`endif

    assign rsp_valid = rsp_valid_q;
    assign dac_sclk  = sclk_q;
    assign dac_sen   = sen_q;
    assign dac_smosi = smosi_q;

endmodule
